// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory port between the IF (fetch) and MEM (data)
// requesters, sequencing IDLE -> ACCESS -> WAIT -> DONE for each access.
// Data requests win over fetch until fetch has been passed over STARVE_MAX
// times in a row, after which fetch is granted.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   if_req/if_addr      fetch request (level) and word-aligned byte address
//   if_gnt/if_done      one-cycle pulses: fetch issued / fetch data valid
//   if_rdata/if_stall   held fetch data; if_req & ~if_done
//   d_req/d_we/d_addr/d_wdata   data request, store flag, address, store data
//   d_gnt/d_done        one-cycle pulses: data issued / data complete
//   d_rdata/d_stall     held load data; d_req & ~d_done
//   mem_*               single memory port (rdata valid MEM_LAT cycles after en)
//   perf_if_wait        fetch stall-cycle count (ARB_PERF_EN)
//   perf_d_grants       data grant count (ARB_PERF_EN)
//
// Build option: define ARB_PERF_EN to include the performance counters;
// without it both perf ports are tied to zero.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_done,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_stall,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_stall,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [31:0]       perf_if_wait,
    output logic [31:0]       perf_d_grants
);

    localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int SW = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WAIT,
        DONE
    } state_t;

    state_t            state;
    state_t            state_d;
    logic              own_if;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [CW-1:0]     wait_cnt;
    logic [SW-1:0]     starve_cnt;

    logic starved;
    logic pick_if;
    logic pick_d;
    logic last_wait;

    // Fetch is forced through only once it has been passed over enough.
    assign starved   = (starve_cnt == SW'(STARVE_MAX));
    assign pick_if   = if_req & (~d_req | starved);
    assign pick_d    = d_req & ~pick_if;
    assign last_wait = (wait_cnt == CW'(MEM_LAT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE:    if (pick_if | pick_d) state_d = ACCESS;
            ACCESS:  state_d = WAIT;
            WAIT:    if (last_wait) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_en  = 1'b0;
        mem_we  = 1'b0;
        if_gnt  = 1'b0;
        d_gnt   = 1'b0;
        if_done = 1'b0;
        d_done  = 1'b0;
        unique case (state)
            ACCESS: begin
                mem_en = 1'b1;
                mem_we = we_q;
                if_gnt = own_if;
                d_gnt  = ~own_if;
            end
            DONE: begin
                if_done = own_if;
                d_done  = ~own_if;
            end
            default: ;
        endcase
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    // Gated by reset so every output reads 0 while reset is held.
    assign if_stall = if_req & ~if_done & ~reset;
    assign d_stall  = d_req & ~d_done & ~reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            own_if     <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wait_cnt   <= '0;
            starve_cnt <= '0;
            if_rdata   <= '0;
            d_rdata    <= '0;
        end else begin
            if (state == IDLE) begin
                if (pick_if | pick_d) begin
                    own_if  <= pick_if;
                    we_q    <= pick_d & d_we;
                    addr_q  <= pick_if ? if_addr : d_addr;
                    wdata_q <= pick_d ? d_wdata : '0;
                end
                if (!if_req || pick_if) begin
                    starve_cnt <= '0;
                end else if (pick_d && !starved) begin
                    starve_cnt <= starve_cnt + 1'b1;
                end
            end
            if (state == WAIT && !last_wait) begin
                wait_cnt <= wait_cnt + 1'b1;
            end else begin
                wait_cnt <= '0;
            end
            if (state == WAIT && last_wait && !we_q) begin
                if (own_if) begin
                    if_rdata <= mem_rdata;
                end else begin
                    d_rdata <= mem_rdata;
                end
            end
        end
    end

`ifdef ARB_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_if_wait  <= '0;
            perf_d_grants <= '0;
        end else begin
            if (if_stall) perf_if_wait <= perf_if_wait + 32'd1;
            if (d_gnt) perf_d_grants <= perf_d_grants + 32'd1;
        end
    end
`else
    assign perf_if_wait  = '0;
    assign perf_d_grants = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Random-traffic bench for mem_port_arbiter with a transaction-level model
// that predicts grant/done cycles and memory contents from the arbitration rules.
module tb_mem_port_arbiter;

    localparam int LAT  = 3;
    localparam int SMAX = 2;
    localparam int NCYC = 3000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_gnt, if_done, if_stall;
    logic [31:0] if_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        d_gnt, d_done, d_stall;
    logic [31:0] d_rdata;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [31:0] perf_if_wait, perf_d_grants;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT), .STARVE_MAX(SMAX)
    ) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_done(if_done), .if_rdata(if_rdata), .if_stall(if_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_done(d_done), .d_rdata(d_rdata), .d_stall(d_stall),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .perf_if_wait(perf_if_wait), .perf_d_grants(perf_d_grants)
    );

    // Environment memory: garbage on rdata except in the valid cycle.
    logic [31:0] ram [64];
    logic [31:0] rd_pipe [LAT];

    always @(posedge clk) begin
        if (mem_en && mem_we) ram[mem_addr[7:2]] <= mem_wdata;
        rd_pipe[0] <= (mem_en && !mem_we) ? ram[mem_addr[7:2]] : $urandom;
        for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_rdata = rd_pipe[LAT-1];

    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    // Reference model state
    logic [31:0] refm [64];
    int          next_idle, g_cyc, dn_cyc, starve;
    bit          own_if, t_we;
    logic [31:0] t_addr, t_wdata, t_rdata;
    logic [31:0] e_if_rdata, e_d_rdata;
    int          e_pif, e_pd;
    bit          prev_if_done, prev_d_done;
    bit          if_pend, d_pend;
    int          n_resets;

    task automatic model_reset(input int idle_at);
        next_idle    = idle_at;
        g_cyc        = -10;
        dn_cyc       = -10;
        starve       = 0;
        e_if_rdata   = '0;
        e_d_rdata    = '0;
        e_pif        = 0;
        e_pd         = 0;
        prev_if_done = 0;
        prev_d_done  = 0;
    endtask

    task automatic drive();
        if (prev_if_done) if_pend = 0;
        if (prev_d_done) d_pend = 0;
        if (!if_pend && $urandom_range(0, 3) != 0) begin
            if_pend = 1;
            if_addr = 32'($urandom_range(0, 63)) << 2;
        end
        if (!d_pend && $urandom_range(0, 3) != 0) begin
            d_pend  = 1;
            d_we    = 1'($urandom_range(0, 1));
            d_addr  = 32'($urandom_range(0, 63)) << 2;
            d_wdata = $urandom;
        end
        if_req = if_pend;
        d_req  = d_pend;
    endtask

    task automatic model_check();
        bit eig, edg, eid, edd, wi, wd;
        eig = (cyc == g_cyc) && own_if;
        edg = (cyc == g_cyc) && !own_if;
        eid = (cyc == dn_cyc) && own_if;
        edd = (cyc == dn_cyc) && !own_if;
        if (cyc == dn_cyc && !t_we) begin
            if (own_if) e_if_rdata = t_rdata;
            else e_d_rdata = t_rdata;
        end
        chk("if_gnt", if_gnt, eig);
        chk("d_gnt", d_gnt, edg);
        chk("if_done", if_done, eid);
        chk("d_done", d_done, edd);
        chk("if_stall", if_stall, if_req & ~eid);
        chk("d_stall", d_stall, d_req & ~edd);
        chk("mem_en", mem_en, cyc == g_cyc);
        chk("if_rdata", if_rdata, e_if_rdata);
        chk("d_rdata", d_rdata, e_d_rdata);
        if (cyc == g_cyc) begin
            chk("mem_we", mem_we, t_we);
            chk("mem_addr", mem_addr, t_addr);
            if (t_we) chk("mem_wdata", mem_wdata, t_wdata);
        end
`ifdef ARB_PERF_EN
        chk("perf_if_wait", perf_if_wait, e_pif);
        chk("perf_d_grants", perf_d_grants, e_pd);
        e_pif += int'(if_req & ~eid);
        e_pd  += int'(edg);
`else
        chk("perf_if_wait", perf_if_wait, 0);
        chk("perf_d_grants", perf_d_grants, 0);
`endif
        prev_if_done = eid;
        prev_d_done  = edd;
        if (cyc >= next_idle) begin
            wi = if_req && (!d_req || starve == SMAX);
            wd = d_req && !wi;
            if (!if_req || wi) starve = 0;
            else if (wd && starve < SMAX) starve++;
            if (wi || wd) begin
                own_if    = wi;
                t_we      = wd && d_we;
                t_addr    = wi ? if_addr : d_addr;
                t_wdata   = d_wdata;
                g_cyc     = cyc + 1;
                dn_cyc    = cyc + LAT + 2;
                next_idle = cyc + LAT + 3;
                if (t_we) refm[t_addr[7:2]] = t_wdata;
                else t_rdata = refm[t_addr[7:2]];
            end
        end
    endtask

    task automatic chk_reset_outputs();
        chk("rst_if_gnt", if_gnt, 0);
        chk("rst_d_gnt", d_gnt, 0);
        chk("rst_if_done", if_done, 0);
        chk("rst_d_done", d_done, 0);
        chk("rst_if_stall", if_stall, 0);
        chk("rst_d_stall", d_stall, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_d_rdata", d_rdata, 0);
        chk("rst_perf_if", perf_if_wait, 0);
        chk("rst_perf_d", perf_d_grants, 0);
    endtask

    initial begin
        bit in_reset;
        for (int i = 0; i < 64; i++) begin
            ram[i]  = $urandom;
            refm[i] = ram[i];
        end
        if_pend  = 0;
        d_pend   = 0;
        n_resets = 0;
        in_reset = 0;
        #1;
        chk_reset_outputs();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        cyc = 0;
        model_reset(0);
        drive();
        for (int k = 0; k < NCYC; k++) begin
            @(negedge clk);
            model_check();
            if (k > 50 && n_resets < 4 && cyc == g_cyc + 1 && !own_if &&
                !t_we && $urandom_range(0, 3) == 0) begin
                #2;
                reset = 1'b1;
                #1;
                chk_reset_outputs();
                n_resets++;
                in_reset = 1;
                model_reset(cyc + 1);
            end
            @(posedge clk);
            #1;
            cyc++;
            if (in_reset) begin
                reset    = 1'b0;
                in_reset = 0;
            end
            drive();
        end
        chk("reset_count", n_resets > 0, 1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
